sw_seq_writer: RTL and testbench

Host-side writer that fills the T and Q sequence SRAMs which the Smith-Waterman core reads. It packs a stream of 2-bit nucleotide symbols into SRAM words and writes a length header. It then issues a one-cycle start pulse to the core once both sequences are loaded and the core is idle. It sits between the host/testbench stream and the SRAM write ports, mirroring the core's read-side select/address/data interface.

---
 rtl/sw_seq_writer_pkg.sv | 23 ++
 rtl/sw_sym_packer.sv | 46 ++++
 rtl/sw_seq_writer.sv | 163 ++++++++++++++++
 tb/tb_sw_seq_writer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sw_seq_writer_pkg.sv
// Shared constants and state encoding for the Smith-Waterman sequence writer.
// Defaults match the SRAM geometry the core reads from.
package sw_seq_writer_pkg;

   localparam int SRAM_WORD_WIDTH = 64;
   localparam int SRAM_ADDR_BIT   = 10;

   localparam logic [1:0] SYM_A = 2'd0;
   localparam logic [1:0] SYM_C = 2'd1;
   localparam logic [1:0] SYM_G = 2'd2;
   localparam logic [1:0] SYM_T = 2'd3;

   localparam int HDR_ADDR = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_FLUSH,
      ST_HEADER,
      ST_DONE
   } state_t;

endpackage

// File: rtl/sw_sym_packer.sv
// Packs symbols LSB-first into SRAM words; reports word-complete and the
// partial word left over when the last symbol arrives mid-word.
module sw_sym_packer #(
   parameter int WORD_WIDTH = 64,
   parameter int SYM_BIT    = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  push,
   input  logic                  last,
   input  logic [SYM_BIT-1:0]    sym,
   output logic [WORD_WIDTH-1:0] word,
   output logic                  full,
   output logic                  flush
);

   localparam int SPW   = WORD_WIDTH / SYM_BIT;
   localparam int IDX_W = $clog2(SPW);

   logic [WORD_WIDTH-1:0] pack;
   logic [IDX_W-1:0]      idx;

   // word is the pack register with the incoming symbol merged in
   always_comb begin
      word = pack;
      word[idx*SYM_BIT +: SYM_BIT] = sym;
   end

   assign full  = push & (idx == IDX_W'(SPW - 1));
   assign flush = push & last & ~full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pack <= '0;
         idx  <= '0;
      end else if (clr || (push && (full || last))) begin
         pack <= '0;
         idx  <= '0;
      end else if (push) begin
         pack <= word;
         idx  <= idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/sw_seq_writer.sv
// Loads T/Q sequence SRAMs from a symbol stream and starts the SW core.
// Optional macro SW_WRITER_AUTOSTART_EN: start once both sequences are loaded.
module sw_seq_writer
   import sw_seq_writer_pkg::*;
#(
   parameter int WORD_WIDTH = SRAM_WORD_WIDTH,
   parameter int ADDR_BIT   = SRAM_ADDR_BIT,
   parameter int SYM_BIT    = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  begin_i,
   input  logic                  sel_q_i,
   input  logic [SYM_BIT-1:0]    sym_i,
   input  logic                  sym_valid_i,
   input  logic                  sym_last_i,
   output logic                  sym_ready_o,
   output logic                  wr_en_o,
   output logic                  wr_sel_T_o,
   output logic [ADDR_BIT-1:0]   wr_addr_o,
   output logic [WORD_WIDTH-1:0] wr_data_o,
   input  logic                  go_i,
   input  logic                  sw_busy_i,
   output logic                  sw_start_o,
   output logic                  done_o,
   output logic                  overflow_o,
   output logic [ADDR_BIT+$clog2(WORD_WIDTH/SYM_BIT)-1:0] len_o
);

   localparam int SPW     = WORD_WIDTH / SYM_BIT;
   localparam int LEN_BIT = ADDR_BIT + $clog2(SPW);
   localparam int CAP_INT = ((1 << ADDR_BIT) - 1) * SPW;
   localparam logic [LEN_BIT-1:0] CAP = LEN_BIT'(CAP_INT);

   state_t state, state_nx;

   logic                  sel_q;
   logic [LEN_BIT-1:0]    cnt;
   logic [ADDR_BIT-1:0]   waddr;
   logic                  t_loaded, q_loaded;
   logic                  go_pending, wait_busy;
   logic                  take, acc, at_cap, push;
   logic                  full, flush, auto_go;
   logic [WORD_WIDTH-1:0] word;

   assign take   = (state == ST_IDLE) & begin_i;
   assign acc    = (state == ST_FILL) & sym_valid_i;
   assign at_cap = (cnt == CAP);
   assign push   = acc & ~at_cap;

   sw_sym_packer #(
      .WORD_WIDTH(WORD_WIDTH),
      .SYM_BIT   (SYM_BIT)
   ) u_packer (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (take),
      .push (push),
      .last (sym_last_i),
      .sym  (sym_i),
      .word (word),
      .full (full),
      .flush(flush)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      sym_ready_o = 1'b0;
      done_o      = 1'b0;
      unique case (state)
         ST_IDLE:   if (begin_i) state_nx = ST_FILL;
         ST_FILL: begin
            sym_ready_o = 1'b1;
            if (acc && sym_last_i) state_nx = ST_FLUSH;
         end
         ST_FLUSH:  state_nx = ST_HEADER;
         ST_HEADER: state_nx = ST_DONE;
         ST_DONE: begin
            done_o   = 1'b1;
            state_nx = ST_IDLE;
         end
         default:   state_nx = ST_IDLE;
      endcase
   end

   // Data and partial words are registered on acceptance, so the
   // partial word lands in the FLUSH cycle and the header in HEADER.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q      <= 1'b0;
         cnt        <= '0;
         waddr      <= '0;
         overflow_o <= 1'b0;
         len_o      <= '0;
         wr_en_o    <= 1'b0;
         wr_sel_T_o <= 1'b0;
         wr_addr_o  <= '0;
         wr_data_o  <= '0;
      end else begin
         wr_en_o <= 1'b0;
         if (take) begin
            sel_q      <= sel_q_i;
            cnt        <= '0;
            waddr      <= ADDR_BIT'(1);
            overflow_o <= 1'b0;
         end
         if (push) cnt <= cnt + LEN_BIT'(1);
         if (acc && at_cap) overflow_o <= 1'b1;
         if (full || flush) begin
            wr_en_o    <= 1'b1;
            wr_sel_T_o <= ~sel_q;
            wr_addr_o  <= waddr;
            wr_data_o  <= word;
         end
         if (full) waddr <= waddr + ADDR_BIT'(1);
         if (state == ST_FLUSH) begin
            wr_en_o    <= 1'b1;
            wr_sel_T_o <= ~sel_q;
            wr_addr_o  <= ADDR_BIT'(HDR_ADDR);
            wr_data_o  <= WORD_WIDTH'(cnt);
            len_o      <= cnt;
         end
      end
   end

`ifdef SW_WRITER_AUTOSTART_EN
   assign auto_go = (state == ST_DONE) & (sel_q ? t_loaded : q_loaded);
`else
   assign auto_go = 1'b0;
`endif

   assign sw_start_o = go_pending & t_loaded & q_loaded & ~sw_busy_i
                     & ~wait_busy & (state == ST_IDLE);

   // wait_busy hides the core's input-register delay after a start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_loaded   <= 1'b0;
         q_loaded   <= 1'b0;
         go_pending <= 1'b0;
         wait_busy  <= 1'b0;
      end else begin
         if (take) begin
            if (sel_q_i) q_loaded <= 1'b0;
            else         t_loaded <= 1'b0;
         end
         if (state == ST_DONE) begin
            if (sel_q) q_loaded <= 1'b1;
            else       t_loaded <= 1'b1;
         end
         if (sw_start_o)             go_pending <= 1'b0;
         else if (go_i || auto_go)   go_pending <= 1'b1;
         if (sw_start_o)             wait_busy <= 1'b1;
         else if (sw_busy_i)         wait_busy <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sw_seq_writer.sv
// Directed bench for sw_seq_writer: default geometry plus an ADDR_BIT=2
// instance for the capacity/overflow case.
module tb_sw_seq_writer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       begin1 = 1'b0, begin2 = 1'b0;
   logic       sel_q_i = 1'b0;
   logic [1:0] sym_i = 2'd0;
   logic       sym_valid_i = 1'b0, sym_last_i = 1'b0;
   logic       go_i = 1'b0, sw_busy_i = 1'b0;

   logic        rdy1, wen1, wsel1, start1, done1, ovf1;
   logic [9:0]  wa1;
   logic [63:0] wd1;
   logic [14:0] len1;

   logic        rdy2, wen2, wsel2, start2, done2, ovf2;
   logic [1:0]  wa2;
   logic [63:0] wd2;
   logic [6:0]  len2;

   int checks = 0;
   int failures = 0;

   logic [79:0] log1[$];
   logic [79:0] log2[$];

   always #5 clk = ~clk;

   sw_seq_writer dut1 (
      .clk(clk), .rst_n(rst_n), .begin_i(begin1), .sel_q_i(sel_q_i),
      .sym_i(sym_i), .sym_valid_i(sym_valid_i), .sym_last_i(sym_last_i),
      .sym_ready_o(rdy1), .wr_en_o(wen1), .wr_sel_T_o(wsel1),
      .wr_addr_o(wa1), .wr_data_o(wd1), .go_i(go_i), .sw_busy_i(sw_busy_i),
      .sw_start_o(start1), .done_o(done1), .overflow_o(ovf1), .len_o(len1)
   );

   sw_seq_writer #(.ADDR_BIT(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .begin_i(begin2), .sel_q_i(sel_q_i),
      .sym_i(sym_i), .sym_valid_i(sym_valid_i), .sym_last_i(sym_last_i),
      .sym_ready_o(rdy2), .wr_en_o(wen2), .wr_sel_T_o(wsel2),
      .wr_addr_o(wa2), .wr_data_o(wd2), .go_i(1'b0), .sw_busy_i(1'b0),
      .sw_start_o(start2), .done_o(done2), .overflow_o(ovf2), .len_o(len2)
   );

   always @(negedge clk) begin
      if (wen1) log1.push_back({5'd0, wsel1, wa1, wd1});
      if (wen2) log2.push_back({5'd0, wsel2, 8'd0, wa2, wd2});
   end

   function automatic logic [79:0] ent(input logic s, input logic [9:0] a,
                                       input logic [63:0] d);
      return {5'd0, s, a, d};
   endfunction

   task automatic check(input string tag, input logic [79:0] got,
                        input logic [79:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // symbol k carries value k mod 4; done must arrive exactly 3 cycles late
   task automatic load(input bit d2, input bit selq, input int n,
                       input string tag);
      logic [2:0] dn;
      @(posedge clk); #1;
      if (d2) begin2 = 1'b1;
      else    begin1 = 1'b1;
      sel_q_i = selq;
      @(posedge clk); #1;
      begin1 = 1'b0;
      begin2 = 1'b0;
      for (int k = 0; k < n; k++) begin
         sym_i       = k[1:0];
         sym_valid_i = 1'b1;
         sym_last_i  = (k == n - 1);
         @(posedge clk); #1;
      end
      sym_valid_i = 1'b0;
      sym_last_i  = 1'b0;
      dn = 3'b000;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         dn = {dn[1:0], (d2 ? done2 : done1)};
      end
      check({tag, "_done_lat"}, 80'(dn), 80'(3'b001));
   endtask

   localparam logic [63:0] E4W = 64'hE4E4_E4E4_E4E4_E4E4;

   initial begin
      int n;
      #12;
      check("rst_outs1", 80'({rdy1, wen1, wsel1, start1, done1, ovf1,
                              len1, wa1}), 80'd0);
      check("rst_outs2", 80'({rdy2, wen2, wsel2, start2, done2, ovf2,
                              len2}), 80'd0);
      @(negedge clk);
      rst_n = 1'b1;

      log1.delete();
      load(1'b0, 1'b0, 70, "t70");
      check("t70_nwr", 80'(log1.size()), 80'd4);
      check("t70_w0", log1[0], ent(1'b1, 10'd1, E4W));
      check("t70_w1", log1[1], ent(1'b1, 10'd2, E4W));
      // six symbols 0,1,2,3,0,1 occupy twelve bits
      check("t70_w2", log1[2], ent(1'b1, 10'd3, 64'h4E4));
      check("t70_hdr", log1[3], ent(1'b1, 10'd0, 64'd70));
      check("t70_len", 80'(len1), 80'd70);
      check("t70_ovf", 80'(ovf1), 80'd0);

      log1.delete();
      load(1'b0, 1'b1, 32, "q32");
      check("q32_nwr", 80'(log1.size()), 80'd2);
      check("q32_w0", log1[0], ent(1'b0, 10'd1, E4W));
      check("q32_hdr", log1[1], ent(1'b0, 10'd0, 64'd32));
      check("q32_len", 80'(len1), 80'd32);

`ifdef SW_WRITER_AUTOSTART_EN
      @(negedge clk);
      check("auto_start", 80'(start1), 80'd1);
      @(posedge clk); #1 sw_busy_i = 1'b1;
      @(posedge clk); #1 sw_busy_i = 1'b0;
`endif

      @(posedge clk); #1 go_i = 1'b1;
      @(posedge clk); #1 go_i = 1'b0;
      @(negedge clk);
      check("go_start", 80'(start1), 80'd1);
      n = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (start1) n++;
      end
      check("go_single", 80'(n), 80'd0);
      @(posedge clk); #1 go_i = 1'b1;
      @(posedge clk); #1 go_i = 1'b0;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (start1) n++;
      end
      check("no_repulse", 80'(n), 80'd0);

      @(posedge clk); #1;
      sw_busy_i = 1'b1;
      go_i = 1'b1;
      @(posedge clk); #1 go_i = 1'b0;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (start1) n++;
      end
      check("busy_hold", 80'(n), 80'd0);
      @(posedge clk); #1 sw_busy_i = 1'b0;
      @(negedge clk);
      check("busy_release", 80'(start1), 80'd1);
      @(negedge clk);
      check("busy_once", 80'(start1), 80'd0);

      log2.delete();
      load(1'b1, 1'b0, 100, "cap");
      check("cap_nwr", 80'(log2.size()), 80'd4);
      check("cap_w0", log2[0], ent(1'b1, 10'd1, E4W));
      check("cap_w1", log2[1], ent(1'b1, 10'd2, E4W));
      check("cap_w2", log2[2], ent(1'b1, 10'd3, E4W));
      check("cap_hdr", log2[3], ent(1'b1, 10'd0, 64'd96));
      check("cap_ovf", 80'(ovf2), 80'd1);
      check("cap_len", 80'(len2), 80'd96);
      check("dut1_quiet_ovf", 80'(ovf1), 80'd0);
      load(1'b1, 1'b1, 2, "cap2");
      check("cap_ovf_clr", 80'(ovf2), 80'd0);

      @(posedge clk); #1;
      begin1  = 1'b1;
      sel_q_i = 1'b0;
      @(posedge clk); #1 begin1 = 1'b0;
      for (int k = 0; k < 10; k++) begin
         sym_i       = k[1:0];
         sym_valid_i = 1'b1;
         @(posedge clk); #1;
      end
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_outs", 80'({rdy1, wen1, wsel1, start1, done1, ovf1,
                                 len1, wa1}), 80'd0);
      sym_valid_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1 go_i = 1'b1;
      @(posedge clk); #1 go_i = 1'b0;
      n = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (start1) n++;
      end
      check("rst_no_start", 80'(n), 80'd0);
      load(1'b0, 1'b0, 3, "rl_t");
      check("rl_t_no_start", 80'(start1), 80'd0);
      load(1'b0, 1'b1, 3, "rl_q");
      @(negedge clk);
      check("rl_start", 80'(start1), 80'd1);
      check("rl_len", 80'(len1), 80'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
